// File: rtl/bp_assoc_cache.sv
// bp_assoc_cache: set-associative branch-prediction store.
// Two combinational lookup ports, one synchronous update port, per-set
// round-robin replacement and a multi-cycle flush sweep.
// Optional statistics counters: define BP_ASSOC_CACHE_STATS_EN.
module bp_assoc_cache #(
  parameter int AWIDTH = 30,
  parameter int DWIDTH = 2,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              flush,
  output logic              busy
`ifdef BP_ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_allocs
`endif
);

  localparam int IDX = $clog2(SETS);
  localparam int TW  = AWIDTH - IDX;
  localparam int RW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [IDX-1:0]    cnt_q, cnt_d;

  logic [TW-1:0]     tag_q   [SETS][WAYS];
  logic [DWIDTH-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [RW-1:0]     rr_q    [SETS];

  logic [IDX-1:0]    wset;
  logic [TW-1:0]     wtag;
  logic              whit, has_inv, accept;
  logic [RW-1:0]     hit_way, inv_way, fill_way, wi;

  // Returns {hit, data} for one lookup address.
  function automatic logic [DWIDTH:0] lookup(input logic [AWIDTH-1:0] a);
    logic [IDX-1:0] s;
    logic [TW-1:0]  t;
    logic [RW-1:0]  k;
    s = a[IDX-1:0];
    t = a[AWIDTH-1:IDX];
    lookup = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      k = RW'(w);
      if (valid_q[s][k] && tag_q[s][k] == t) lookup = {1'b1, data_q[s][k]};
    end
  endfunction

  assign wset   = wa[IDX-1:0];
  assign wtag   = wa[AWIDTH-1:IDX];
  assign accept = we && (state_q == IDLE) && !flush;

  always_comb begin
    whit    = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    wi      = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      wi = RW'(w);
      if (valid_q[wset][wi] && tag_q[wset][wi] == wtag) begin
        whit    = 1'b1;
        hit_way = wi;
      end
      if (!valid_q[wset][wi] && !has_inv) begin
        has_inv = 1'b1;
        inv_way = wi;
      end
    end
    fill_way = has_inv ? inv_way : ((WAYS > 1) ? rr_q[wset] : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SWEEP);
    {hit0, dout0} = busy ? '0 : lookup(ra0);
    {hit1, dout1} = busy ? '0 : lookup(ra1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '{default: '0};
      rr_q    <= '{default: '0};
    end else if (state_q == SWEEP) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (accept && !whit) begin
      valid_q[wset][fill_way] <= 1'b1;
      if (!has_inv && WAYS > 1) rr_q[wset] <= rr_q[wset] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (whit) begin
        data_q[wset][hit_way] <= din;
      end else begin
        tag_q[wset][fill_way]  <= wtag;
        data_q[wset][fill_way] <= din;
      end
    end
  end

`ifdef BP_ASSOC_CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates <= '0;
      stat_allocs  <= '0;
    end else if (accept) begin
      if (whit) stat_updates <= stat_updates + 32'd1;
      else      stat_allocs  <= stat_allocs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_assoc_cache.sv
// Scoreboard bench for bp_assoc_cache (SETS=64, WAYS=2, AWIDTH=30, DWIDTH=2).
module tb_bp_assoc_cache;
  localparam int AW = 30;
  localparam int DW = 2;
  localparam int NS = 64;
  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [AW-1:0] ra0 = '0, ra1 = '0, wa = '0;
  logic [DW-1:0] din = '0;
  logic          we = 1'b0, flush = 1'b0;
  logic [DW-1:0] dout0, dout1;
  logic          hit0, hit1, busy;
`ifdef BP_ASSOC_CACHE_STATS_EN
  logic [31:0]   stat_updates, stat_allocs;
`endif

  bp_assoc_cache #(.AWIDTH(AW), .DWIDTH(DW), .SETS(NS), .WAYS(NW)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we), .flush(flush), .busy(busy)
`ifdef BP_ASSOC_CACHE_STATS_EN
    , .stat_updates(stat_updates), .stat_allocs(stat_allocs)
`endif
  );

  typedef struct {
    logic          h0;
    logic [DW-1:0] d0;
    logic          h1;
    logic [DW-1:0] d1;
    logic          bsy;
    logic [31:0]   su;
    logic [31:0]   sa;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a table of remembered branches per set, with slot order
  // kept so the round-robin victim can be named; a flush simply forgets
  // everything and hides the table for NS cycles.
  bit          m_valid [NS][NW];
  int unsigned m_tag   [NS][NW];
  int unsigned m_data  [NS][NW];
  int unsigned m_rr    [NS];
  int unsigned m_busy;
  logic [31:0] m_upd, m_alloc;

  task automatic model_reset();
    foreach (m_valid[s, w]) m_valid[s][w] = 1'b0;
    foreach (m_rr[s]) m_rr[s] = 0;
    m_busy  = 0;
    m_upd   = '0;
    m_alloc = '0;
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    int unsigned s, t;
    s = a % NS;
    t = a / NS;
    h = 1'b0;
    d = '0;
    if (m_busy == 0)
      for (int w = 0; w < NW; w++)
        if (m_valid[s][w] && m_tag[s][w] == t) begin
          h = 1'b1;
          d = DW'(m_data[s][w]);
        end
  endtask

  task automatic model_edge(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w_e, input logic f, input logic rs);
    int unsigned s, t;
    int slot;
    if (rs) begin
      model_reset();
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
    end else if (f) begin
      foreach (m_valid[i, j]) m_valid[i][j] = 1'b0;
      foreach (m_rr[i]) m_rr[i] = 0;
      m_busy = NS;
    end else if (w_e) begin
      s = a % NS;
      t = a / NS;
      slot = -1;
      for (int w = 0; w < NW; w++)
        if (m_valid[s][w] && m_tag[s][w] == t) slot = w;
      if (slot >= 0) begin
        m_data[s][slot] = d;
        m_upd++;
      end else begin
        for (int w = NW - 1; w >= 0; w--)
          if (!m_valid[s][w]) slot = w;
        if (slot < 0) begin
          slot    = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % NW;
        end
        m_valid[s][slot] = 1'b1;
        m_tag[s][slot]   = t;
        m_data[s][slot]  = d;
        m_alloc++;
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected view, then advance the model.
  task automatic tick(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic w_e, input logic f, input logic rs);
    exp_t e;
    ra0 = r0; ra1 = r1; wa = a; din = d; we = w_e; flush = f; reset = rs;
    if (rs) model_reset();
    model_read(r0, e.h0, e.d0);
    model_read(r1, e.h1, e.d1);
    e.bsy = (m_busy > 0);
    e.su  = m_upd;
    e.sa  = m_alloc;
    q.push_back(e);
    @(posedge clk);
    model_edge(a, d, w_e, f, rs);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    tick(r0, r1, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] r0);
    tick(r0, a, a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hit0", 32'(hit0), 32'(e.h0));
        chk("dout0", 32'(dout0), 32'(e.d0));
        chk("hit1", 32'(hit1), 32'(e.h1));
        chk("dout1", 32'(dout1), 32'(e.d1));
        chk("busy", 32'(busy), 32'(e.bsy));
`ifdef BP_ASSOC_CACHE_STATS_EN
        chk("stat_updates", stat_updates, e.su);
        chk("stat_allocs", stat_allocs, e.sa);
`endif
      end
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    return AW'((($urandom_range(0, 5)) << 6) | $urandom_range(0, 3));
  endfunction

  initial begin : driver
    logic [AW-1:0] a;
    model_reset();
    @(posedge clk);
    #1;
    // reset state
    tick(30'h40, 30'h40, '0, '0, 1'b0, 1'b0, 1'b1);
    tick(30'h40, 30'h40, '0, '0, 1'b0, 1'b0, 1'b0);
    // first write, same-cycle read sees pre-write contents
    wr(30'h40, 2'b11, 30'h40);
    rd(30'h40, 30'h40);
    // same-set fill and round-robin replacement
    wr(30'h05, 2'd1, 30'h05);
    wr(30'h45, 2'd2, 30'h05);
    rd(30'h05, 30'h45);
    wr(30'h85, 2'd3, 30'h05);
    rd(30'h05, 30'h85);
    rd(30'h45, 30'h85);
    wr(30'hC5, 2'd1, 30'h45);
    rd(30'h45, 30'hC5);
    rd(30'h85, 30'h05);
    // update hit leaves pointer and neighbours alone
    wr(30'h85, 2'd0, 30'h85);
    rd(30'h85, 30'hC5);
    wr(30'h105, 2'd2, 30'h85);
    rd(30'h85, 30'h105);
    rd(30'hC5, 30'h105);
    // fill several sets, then flush with writes arriving mid-sweep
    for (int i = 1; i < 9; i++) wr(AW'(i), DW'(i), AW'(i - 1));
    tick(30'h3, 30'h105, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NS; i++)
      tick(AW'(i % 9), 30'h105, AW'(i % 9), 2'd3, (i % 5) == 2, i == 7, 1'b0);
    for (int i = 0; i < 9; i++) rd(AW'(i), 30'h105);
    wr(30'h07, 2'd1, 30'h07);
    wr(30'h47, 2'd2, 30'h07);
    wr(30'h87, 2'd3, 30'h47);
    rd(30'h07, 30'h87);
    // flush and write in the same idle cycle: write is dropped
    tick(30'h200, 30'h200, 30'h200, 2'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NS; i++) rd(30'h200, 30'h87);
    rd(30'h200, 30'h87);
    // reset mid-sweep
    wr(30'h11, 2'd3, 30'h11);
    tick(30'h11, 30'h11, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) rd(30'h11, 30'h11);
    tick(30'h11, 30'h11, '0, '0, 1'b0, 1'b0, 1'b1);
    rd(30'h11, 30'h11);
    wr(30'h11, 2'd2, 30'h11);
    rd(30'h11, 30'h11);
    // randomized traffic over a small pool of sets and tags
    for (int i = 0; i < 3000; i++) begin
      a = rnd_addr();
      tick(rnd_addr(), rnd_addr(), a, DW'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 149) == 0,
           $urandom_range(0, 999) == 0);
    end
    rd('0, '0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
